// File: rtl/poly_synth_if.sv
// -----------------------------------------------------------------------------
// poly_synth_if
// Purpose : groups the control inputs and sample outputs of poly_synth.
// Signals : keys         - key pressed flags, bit k = voice k
//           mode         - waveform select (00 square, 01 triangle, 1x saw)
//           enable       - sample generation runs while high
//           wave         - mixed unsigned sample, registered
//           sample_valid - one-cycle pulse when wave updates
//           clip         - high with sample_valid when the mix saturated
//           active_count - number of keys latched for the current frame
// Modports: master drives keys/mode/enable, slave (the synth) drives outputs.
// -----------------------------------------------------------------------------
interface poly_synth_if #(
  parameter int N_KEYS = 8,
  parameter int WAVE_W = 8
);
  logic [N_KEYS-1:0]               keys;
  logic [1:0]                      mode;
  logic                            enable;
  logic [WAVE_W-1:0]               wave;
  logic                            sample_valid;
  logic                            clip;
  logic [$clog2(N_KEYS+1)-1:0]     active_count;

  modport master (
    output keys, mode, enable,
    input  wave, sample_valid, clip, active_count
  );

  modport slave (
    input  keys, mode, enable,
    output wave, sample_valid, clip, active_count
  );
endinterface

// File: rtl/poly_synth.sv
// -----------------------------------------------------------------------------
// poly_synth
// Purpose : N_KEYS-voice synthesiser. Every SAMPLE_DIV clocks one frame runs:
//           LISTEN latches keys/mode, CHAN steps one voice per cycle through a
//           single shared phase adder and accumulates the voice samples, MIX
//           saturates the sum and PLAY presents it with a one-cycle valid.
// Ports   : clk   - clock, all state on rising edge
//           rst_n - asynchronous active-low reset
//           bus   - poly_synth_if slave (keys, mode, enable in;
//                   wave, sample_valid, clip, active_count out)
// -----------------------------------------------------------------------------
module poly_synth #(
  parameter int                 N_KEYS      = 8,
  parameter int                 WAVE_W      = 8,
  parameter int                 PHASE_W     = 16,
  parameter int                 SAMPLE_DIV  = 256,
  parameter logic [PHASE_W-1:0] BASE_INC    = 16'h0800,
  parameter int                 VOICE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  poly_synth_if.slave bus
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int CH_W  = $clog2(N_KEYS);
  localparam int CNT_W = $clog2(N_KEYS+1);
  // Worst case sum of N_KEYS full-scale voices never overflows this width.
  localparam int ACC_W = WAVE_W + $clog2(N_KEYS) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV-1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_KEYS-1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {{(ACC_W-WAVE_W){1'b0}}, {WAVE_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LISTEN = 3'd1,
    S_CHAN   = 3'd2,
    S_MIX    = 3'd3,
    S_PLAY   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DIV_W-1:0]    r_div_cnt;
  logic                w_tick;
  logic [CH_W-1:0]     r_chan_idx;
  logic [PHASE_W-1:0]  r_inc;
  logic [PHASE_W-1:0]  r_phase [N_KEYS];
  logic [N_KEYS-1:0]   r_keys_lat;
  logic [1:0]          r_mode_lat;
  logic [ACC_W-1:0]    r_acc;
  logic [WAVE_W-1:0]   r_wave;
  logic                r_valid;
  logic                r_clip;
  logic [CNT_W-1:0]    r_active;
  logic [CNT_W-1:0]    w_popcnt;
  logic                w_key_on;
  logic [PHASE_W-1:0]  w_phase_new;
  logic [WAVE_W-1:0]   w_voice;
  logic [ACC_W-1:0]    w_voice_ext;
  logic                w_over;
  logic [WAVE_W-1:0]   w_sat;

  // Waveform shaping from the top WAVE_W phase bits; ~(2t) equals M-(2t).
  function automatic logic [WAVE_W-1:0] voice_sample(input logic [WAVE_W-1:0] t,
                                                     input logic [1:0]        m);
    logic [WAVE_W-1:0] t2;
    t2 = {t[WAVE_W-2:0], 1'b0};
    case (m)
      2'b00:   voice_sample = t[WAVE_W-1] ? {WAVE_W{1'b1}} : {WAVE_W{1'b0}};
      2'b01:   voice_sample = t[WAVE_W-1] ? ~t2 : t2;
      default: voice_sample = t;
    endcase
  endfunction

  assign w_tick = bus.enable && (r_div_cnt == DIV_LAST);

  // Sample-rate divider, parked at zero while generation is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= {DIV_W{1'b0}};
    end else if (!bus.enable) begin
      r_div_cnt <= {DIV_W{1'b0}};
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= {DIV_W{1'b0}};
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; a frame in flight always completes even if enable drops.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_tick) w_state_next = S_LISTEN; else w_state_next = S_IDLE;
      S_LISTEN: w_state_next = S_CHAN;
      S_CHAN:   if (r_chan_idx == CH_LAST) w_state_next = S_MIX; else w_state_next = S_CHAN;
      S_MIX:    w_state_next = S_PLAY;
      S_PLAY:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Number of keys currently pressed, captured at LISTEN.
  always_comb begin
    w_popcnt = {CNT_W{1'b0}};
    for (int i = 0; i < N_KEYS; i++) begin
      w_popcnt = w_popcnt + CNT_W'(bus.keys[i]);
    end
  end

  // Shared voice datapath: one phase update and one sample per CHAN cycle.
  always_comb begin
    w_key_on = r_keys_lat[r_chan_idx];
    if (w_key_on) begin
      w_phase_new = r_phase[r_chan_idx] + r_inc;
      w_voice     = voice_sample(w_phase_new[PHASE_W-1 -: WAVE_W], r_mode_lat);
    end else begin
      w_phase_new = {PHASE_W{1'b0}};
      w_voice     = {WAVE_W{1'b0}};
    end
    w_voice_ext = {{(ACC_W-WAVE_W){1'b0}}, (w_voice >> VOICE_SHIFT)};
    w_over      = (r_acc > ACC_MAX);
    if (w_over) begin
      w_sat = {WAVE_W{1'b1}};
    end else begin
      w_sat = r_acc[WAVE_W-1:0];
    end
  end

  // Frame datapath: latch, per-voice accumulate, saturate and present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan_idx <= {CH_W{1'b0}};
      r_inc      <= {PHASE_W{1'b0}};
      r_keys_lat <= {N_KEYS{1'b0}};
      r_mode_lat <= 2'b00;
      r_acc      <= {ACC_W{1'b0}};
      r_wave     <= {WAVE_W{1'b0}};
      r_valid    <= 1'b0;
      r_clip     <= 1'b0;
      r_active   <= {CNT_W{1'b0}};
      for (int i = 0; i < N_KEYS; i++) begin
        r_phase[i] <= {PHASE_W{1'b0}};
      end
    end else begin
      case (r_state)
        S_LISTEN: begin
          r_keys_lat <= bus.keys;
          r_mode_lat <= bus.mode;
          r_acc      <= {ACC_W{1'b0}};
          r_active   <= w_popcnt;
          r_chan_idx <= {CH_W{1'b0}};
          r_inc      <= BASE_INC;
        end
        S_CHAN: begin
          r_phase[r_chan_idx] <= w_phase_new;
          r_acc               <= r_acc + w_voice_ext;
          r_chan_idx          <= r_chan_idx + CH_W'(1);
          // Running increment gives BASE_INC*(k+1) without a multiplier.
          r_inc               <= r_inc + BASE_INC;
        end
        S_MIX: begin
          r_wave  <= w_sat;
          r_clip  <= w_over;
          r_valid <= 1'b1;
        end
        S_PLAY: begin
          r_valid <= 1'b0;
          r_clip  <= 1'b0;
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wave         = r_wave;
  assign bus.sample_valid = r_valid;
  assign bus.clip         = r_clip;
  assign bus.active_count = r_active;

endmodule

// File: tb/tb_poly_synth.sv
`timescale 1ns/1ps
module tb_poly_synth;
  localparam int NK = 8;
  localparam int WW = 8;
  localparam int PW = 16;
  localparam int SD = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NK-1:0] tb_keys = '0;
  logic [1:0]    tb_mode = 2'b00;
  logic          tb_enable = 1'b0;

  poly_synth_if #(.N_KEYS(NK), .WAVE_W(WW)) bus_a ();
  poly_synth_if #(.N_KEYS(NK), .WAVE_W(WW)) bus_b ();
  assign bus_a.keys = tb_keys;
  assign bus_a.mode = tb_mode;
  assign bus_a.enable = tb_enable;
  assign bus_b.keys = tb_keys;
  assign bus_b.mode = tb_mode;
  assign bus_b.enable = tb_enable;

  // Two copies: default voice shift and an unshifted mix that can clip.
  poly_synth #(.N_KEYS(NK), .WAVE_W(WW), .PHASE_W(PW), .SAMPLE_DIV(SD),
               .BASE_INC(16'h0800), .VOICE_SHIFT(2))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  poly_synth #(.N_KEYS(NK), .WAVE_W(WW), .PHASE_W(PW), .SAMPLE_DIV(SD),
               .BASE_INC(16'h0800), .VOICE_SHIFT(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait at most budget falling edges for a sample_valid pulse on dut_a.
  task automatic wait_pulse(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus_a.sample_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    tb_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: per-voice phase as plain integers.
  int unsigned mph [NK];

  task automatic model_clear();
    for (int v = 0; v < NK; v++) mph[v] = 0;
  endtask

  task automatic model_frame(input logic [NK-1:0] k, input logic [1:0] m,
                             output int wa, output int ca, output int wb,
                             output int cb, output int act);
    int suma, sumb, t, s;
    suma = 0; sumb = 0; act = 0;
    for (int v = 0; v < NK; v++) begin
      if (k[v]) begin
        mph[v] = (mph[v] + 2048 * (v + 1)) % 65536;
        t = mph[v] / 256;
        case (m)
          2'b00:   s = (t >= 128) ? 255 : 0;
          2'b01:   s = (t >= 128) ? 255 - ((2 * t) % 256) : (2 * t) % 256;
          default: s = t;
        endcase
        suma += s / 4;
        sumb += s;
        act++;
      end else begin
        mph[v] = 0;
      end
    end
    wa = (suma > 255) ? 255 : suma;
    ca = (suma > 255) ? 1 : 0;
    wb = (sumb > 255) ? 255 : sumb;
    cb = (sumb > 255) ? 1 : 0;
  endtask

  typedef struct {
    logic [NK-1:0] keys;
    logic [1:0]    mode;
    int            frame;
    logic [7:0]    wa;
    logic          ca;
    logic [7:0]    wb;
    logic          cb;
    logic [3:0]    act;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit seen;
    int c0, p0;
    int ewa, eca, ewb, ecb, eact;
    logic [NK-1:0] lk;
    logic [1:0] lm;

    vecs[0]  = '{8'h01, 2'b10,  1, 8'h02, 1'b0, 8'h08, 1'b0, 4'd1};
    vecs[1]  = '{8'h01, 2'b10,  2, 8'h04, 1'b0, 8'h10, 1'b0, 4'd1};
    vecs[2]  = '{8'h01, 2'b10,  3, 8'h06, 1'b0, 8'h18, 1'b0, 4'd1};
    vecs[3]  = '{8'h01, 2'b11,  2, 8'h04, 1'b0, 8'h10, 1'b0, 4'd1};
    vecs[4]  = '{8'h01, 2'b00,  1, 8'h00, 1'b0, 8'h00, 1'b0, 4'd1};
    vecs[5]  = '{8'h01, 2'b00, 15, 8'h00, 1'b0, 8'h00, 1'b0, 4'd1};
    vecs[6]  = '{8'h01, 2'b00, 16, 8'h3F, 1'b0, 8'hFF, 1'b0, 4'd1};
    vecs[7]  = '{8'h01, 2'b01,  1, 8'h04, 1'b0, 8'h10, 1'b0, 4'd1};
    vecs[8]  = '{8'h01, 2'b01, 16, 8'h3F, 1'b0, 8'hFF, 1'b0, 4'd1};
    vecs[9]  = '{8'hFF, 2'b00, 16, 8'hFC, 1'b0, 8'hFF, 1'b1, 4'd8};
    vecs[10] = '{8'h00, 2'b10,  3, 8'h00, 1'b0, 8'h00, 1'b0, 4'd0};
    vecs[11] = '{8'h03, 2'b10,  1, 8'h06, 1'b0, 8'h18, 1'b0, 4'd2};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_wave", bus_a.wave, 0);
    check("rst_valid", bus_a.sample_valid, 0);
    check("rst_clip", bus_a.clip, 0);
    check("rst_active", bus_a.active_count, 0);
    check("rst_wave_b", bus_b.wave, 0);

    // Table of known frames.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      tb_keys = vecs[i].keys;
      tb_mode = vecs[i].mode;
      tb_enable = 1'b1;
      for (int f = 0; f < vecs[i].frame; f++) begin
        wait_pulse(80, seen);
        check($sformatf("vec%0d_pulse%0d", i, f + 1), seen, 1);
      end
      check($sformatf("vec%0d_wave_a", i), bus_a.wave, vecs[i].wa);
      check($sformatf("vec%0d_clip_a", i), bus_a.clip, vecs[i].ca);
      check($sformatf("vec%0d_wave_b", i), bus_b.wave, vecs[i].wb);
      check($sformatf("vec%0d_clip_b", i), bus_b.clip, vecs[i].cb);
      check($sformatf("vec%0d_active", i), bus_a.active_count, vecs[i].act);
    end

    // Latency, pulse width and spacing from a fresh start.
    do_reset();
    tb_keys = 8'h01; tb_mode = 2'b10; tb_enable = 1'b1;
    c0 = cyc;
    wait_pulse(80, seen);
    check("lat_seen", seen, 1);
    check("lat_first", cyc - c0, 42);
    check("lat_wave", bus_a.wave, 8'h02);
    check("lat_valid_b", bus_b.sample_valid, 1);
    p0 = cyc;
    @(negedge clk);
    check("pulse_width", bus_a.sample_valid, 0);
    check("clip_low_after", bus_b.clip, 0);
    check("wave_hold", bus_a.wave, 8'h02);
    // Keys toggled mid-CHAN must not touch this frame.
    repeat (24) @(negedge clk);
    tb_keys = 8'hFF;
    wait_pulse(20, seen);
    check("tog_seen", seen, 1);
    check("spacing", cyc - p0, 32);
    check("tog_wave", bus_a.wave, 8'h04);
    check("tog_active", bus_a.active_count, 1);
    tb_keys = 8'h01;
    // Reset mid-frame aborts it; outputs clear at once.
    repeat (27) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wave", bus_a.wave, 0);
    check("mid_rst_valid", bus_a.sample_valid, 0);
    check("mid_rst_active", bus_a.active_count, 0);
    check("mid_rst_clip", bus_a.clip, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    wait_pulse(80, seen);
    check("post_rst_seen", seen, 1);
    check("post_rst_lat", cyc - c0, 42);
    check("post_rst_wave", bus_a.wave, 8'h02);
    p0 = cyc;
    // Enable dropped three cycles after tick: frame still completes.
    repeat (24) @(negedge clk);
    tb_enable = 1'b0;
    wait_pulse(20, seen);
    check("en_drop_seen", seen, 1);
    check("en_drop_spacing", cyc - p0, 32);
    check("en_drop_wave", bus_a.wave, 8'h04);
    wait_pulse(100, seen);
    check("en_off_no_pulse", seen, 0);
    tb_enable = 1'b1;
    c0 = cyc;
    wait_pulse(80, seen);
    check("re_en_seen", seen, 1);
    check("re_en_lat", cyc - c0, 42);
    check("re_en_wave", bus_a.wave, 8'h06);

    // Randomised frames against the reference model, with garbage mid-frame.
    do_reset();
    model_clear();
    lk = NK'($urandom);
    lm = 2'($urandom_range(0, 3));
    tb_keys = lk; tb_mode = lm; tb_enable = 1'b1;
    for (int f = 0; f < 40; f++) begin
      wait_pulse(80, seen);
      check($sformatf("rnd%0d_seen", f), seen, 1);
      model_frame(lk, lm, ewa, eca, ewb, ecb, eact);
      check($sformatf("rnd%0d_wave_a", f), bus_a.wave, ewa);
      check($sformatf("rnd%0d_clip_a", f), bus_a.clip, eca);
      check($sformatf("rnd%0d_wave_b", f), bus_b.wave, ewb);
      check($sformatf("rnd%0d_clip_b", f), bus_b.clip, ecb);
      check($sformatf("rnd%0d_active", f), bus_a.active_count, eact);
      lk = NK'($urandom);
      if (f % 5 == 0) lk = 8'hFF;
      lm = 2'($urandom_range(0, 3));
      tb_keys = lk; tb_mode = lm;
      repeat (25) @(negedge clk);
      tb_keys = NK'($urandom);
      tb_mode = 2'($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
